// File: rtl/pc_beat_unit.sv
// Four-beat instruction sequencer with program counter, jump load and retired-instruction counter.
// Every output comes from a register, so no input reaches an output combinationally.
module pc_beat_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        PC_jump_en,
  input  logic [15:0] PC_jump_data,
  output logic        T0,
  output logic        T1,
  output logic        T2,
  output logic        T3,
  output logic [15:0] PC,
  output logic        PC_jump_ack,
  output logic        running,
  output logic [15:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    B3   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  w_beat_nxt;
  logic        w_jump_take;

  logic [3:0]  r_beat;
  logic        r_running;
  logic        r_jump_ack;
  logic [15:0] r_pc;
  logic [15:0] r_instr_cnt;

  // The jump request is only honoured on the write-back beat.
  assign w_jump_take = (r_state == B3) && PC_jump_en;

  // Next-state decode plus the beat strobes that the next state will show.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = 4'b0000;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = B0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      B0:      w_state_nxt = B1;
      B1:      w_state_nxt = B2;
      B2:      w_state_nxt = B3;
      B3: begin
        if (halt) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = B0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    case (w_state_nxt)
      B0:      w_beat_nxt = 4'b0001;
      B1:      w_beat_nxt = 4'b0010;
      B2:      w_beat_nxt = 4'b0100;
      B3:      w_beat_nxt = 4'b1000;
      default: w_beat_nxt = 4'b0000;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered strobes, PC, jump acknowledge and instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= 4'b0000;
      r_running   <= 1'b0;
      r_jump_ack  <= 1'b0;
      r_pc        <= 16'h0000;
      r_instr_cnt <= 16'h0000;
    end else begin
      r_beat     <= w_beat_nxt;
      r_running  <= (w_state_nxt != IDLE);
      r_jump_ack <= w_jump_take;
      // PC is the fetch address during B0 and advances as fetch completes.
      if (r_state == B0) begin
        r_pc <= r_pc + 16'd1;
      end else if (w_jump_take) begin
        r_pc <= PC_jump_data;
      end else begin
        r_pc <= r_pc;
      end
      if (r_state == B3) begin
        r_instr_cnt <= r_instr_cnt + 16'd1;
      end else begin
        r_instr_cnt <= r_instr_cnt;
      end
    end
  end

  assign T0          = r_beat[0];
  assign T1          = r_beat[1];
  assign T2          = r_beat[2];
  assign T3          = r_beat[3];
  assign running     = r_running;
  assign PC_jump_ack = r_jump_ack;
  assign PC          = r_pc;
  assign instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_pc_beat_unit.sv
// Directed bench for pc_beat_unit: inputs driven and outputs sampled on the falling edge.
module tb_pc_beat_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic        PC_jump_en;
  logic [15:0] PC_jump_data;
  logic        T0, T1, T2, T3;
  logic [15:0] PC;
  logic        PC_jump_ack;
  logic        running;
  logic [15:0] instr_cnt;

  int vecs;
  int miss;

  pc_beat_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .PC_jump_en  (PC_jump_en),
    .PC_jump_data(PC_jump_data),
    .T0          (T0),
    .T1          (T1),
    .T2          (T2),
    .T3          (T3),
    .PC          (PC),
    .PC_jump_ack (PC_jump_ack),
    .running     (running),
    .instr_cnt   (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full clock: exactly one rising edge passes, we land on the next falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; halt = 1'b1; PC_jump_en = 1'b1; PC_jump_data = 16'hBEEF;
    cyc();
    cyc();
    vecs++;
    if ({T0, T1, T2, T3} !== 4'b0000 || running !== 1'b0 || PC_jump_ack !== 1'b0) begin
      miss++;
      $display("FAIL reset_ctrl: T=%b running=%b ack=%b, required T=0000 running=0 ack=0",
               {T0, T1, T2, T3}, running, PC_jump_ack);
    end
    vecs++;
    if (PC !== 16'h0000 || instr_cnt !== 16'h0000) begin
      miss++;
      $display("FAIL reset_regs: PC=%h cnt=%h, required 0000/0000", PC, instr_cnt);
    end
    rst = 1'b0; start = 1'b0; halt = 1'b0; PC_jump_en = 1'b0; PC_jump_data = 16'h0000;
    cyc();
    vecs++;
    if (running !== 1'b0 || {T0, T1, T2, T3} !== 4'b0000) begin
      miss++;
      $display("FAIL idle_hold: running=%b T=%b, required 0/0000", running, {T0, T1, T2, T3});
    end
  endtask

  task automatic test_two_instr();
    logic [15:0] exp_pc [8];
    logic [3:0]  exp_t  [8];
    logic [15:0] exp_cnt[8];
    exp_pc  = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0002};
    exp_t   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    exp_cnt = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vecs++;
      if ({T0, T1, T2, T3} !== exp_t[k] || PC !== exp_pc[k] || instr_cnt !== exp_cnt[k] ||
          running !== 1'b1 || PC_jump_ack !== 1'b0) begin
        miss++;
        $display("FAIL two_instr[%0d]: T=%b PC=%h cnt=%h run=%b ack=%b, required T=%b PC=%h cnt=%h run=1 ack=0",
                 k, {T0, T1, T2, T3}, PC, instr_cnt, running, PC_jump_ack, exp_t[k], exp_pc[k], exp_cnt[k]);
      end
      cyc();
    end
    vecs++;
    if (instr_cnt !== 16'h0002 || T0 !== 1'b1 || PC !== 16'h0002) begin
      miss++;
      $display("FAIL two_instr_cnt: cnt=%h T0=%b PC=%h, required 0002/1/0002", instr_cnt, T0, PC);
    end
  endtask

  // Entered in B0 of the third instruction with PC=0002, cnt=0002.
  task automatic test_jump();
    cyc(); cyc(); cyc();
    PC_jump_en = 1'b1; PC_jump_data = 16'h0040;
    vecs++;
    if (T3 !== 1'b1 || PC !== 16'h0003 || PC_jump_ack !== 1'b0) begin
      miss++;
      $display("FAIL jump_b3: T3=%b PC=%h ack=%b, required 1/0003/0", T3, PC, PC_jump_ack);
    end
    cyc();
    PC_jump_en = 1'b0;
    vecs++;
    if (T0 !== 1'b1 || PC !== 16'h0040 || PC_jump_ack !== 1'b1 || instr_cnt !== 16'h0003) begin
      miss++;
      $display("FAIL jump_load: T0=%b PC=%h ack=%b cnt=%h, required 1/0040/1/0003",
               T0, PC, PC_jump_ack, instr_cnt);
    end
    cyc();
    vecs++;
    if (PC_jump_ack !== 1'b0 || PC !== 16'h0041) begin
      miss++;
      $display("FAIL jump_ack_pulse: ack=%b PC=%h, required 0/0041", PC_jump_ack, PC);
    end
  endtask

  // Entered in B1 with PC=0041; jump request held through B0..B2 of the next instruction only.
  task automatic test_jump_ignored();
    cyc(); cyc(); cyc();
    PC_jump_en = 1'b1; PC_jump_data = 16'h1234;
    cyc(); cyc();
    vecs++;
    if (T2 !== 1'b1 || PC !== 16'h0042 || PC_jump_ack !== 1'b0) begin
      miss++;
      $display("FAIL jump_ign_b2: T2=%b PC=%h ack=%b, required 1/0042/0", T2, PC, PC_jump_ack);
    end
    cyc();
    PC_jump_en = 1'b0;
    cyc();
    vecs++;
    if (T0 !== 1'b1 || PC !== 16'h0042 || PC_jump_ack !== 1'b0 || instr_cnt !== 16'h0005) begin
      miss++;
      $display("FAIL jump_ignored: T0=%b PC=%h ack=%b cnt=%h, required 1/0042/0/0005",
               T0, PC, PC_jump_ack, instr_cnt);
    end
  endtask

  // Entered in B0 with PC=0042; jump to FFFF with the counter preset to FFFF.
  task automatic test_wrap();
    cyc(); cyc(); cyc();
    PC_jump_en = 1'b1; PC_jump_data = 16'hFFFF;
    force dut.r_instr_cnt = 16'hFFFF;
    #1;
    release dut.r_instr_cnt;
    cyc();
    PC_jump_en = 1'b0;
    vecs++;
    if (T0 !== 1'b1 || PC !== 16'hFFFF || PC_jump_ack !== 1'b1) begin
      miss++;
      $display("FAIL wrap_jump: T0=%b PC=%h ack=%b, required 1/FFFF/1", T0, PC, PC_jump_ack);
    end
    vecs++;
    if (instr_cnt !== 16'h0000) begin
      miss++;
      $display("FAIL cnt_wrap: cnt=%h, required 0000", instr_cnt);
    end
    cyc();
    vecs++;
    if (T1 !== 1'b1 || PC !== 16'h0000) begin
      miss++;
      $display("FAIL pc_wrap: T1=%b PC=%h, required 1/0000", T1, PC);
    end
  endtask

  // Entered in B1 with PC=0000, cnt=0000; halt rises in B1 and stays up.
  task automatic test_halt();
    halt = 1'b1;
    cyc();
    vecs++;
    if (T2 !== 1'b1 || running !== 1'b1) begin
      miss++;
      $display("FAIL halt_b2: T2=%b run=%b, required 1/1", T2, running);
    end
    cyc();
    vecs++;
    if (T3 !== 1'b1 || running !== 1'b1) begin
      miss++;
      $display("FAIL halt_b3: T3=%b run=%b, required 1/1", T3, running);
    end
    cyc();
    vecs++;
    if ({T0, T1, T2, T3} !== 4'b0000 || running !== 1'b0 || PC !== 16'h0000 || instr_cnt !== 16'h0001) begin
      miss++;
      $display("FAIL halt_idle: T=%b run=%b PC=%h cnt=%h, required 0000/0/0000/0001",
               {T0, T1, T2, T3}, running, PC, instr_cnt);
    end
    halt = 1'b0;
    cyc();
    vecs++;
    if (running !== 1'b0) begin
      miss++;
      $display("FAIL halt_stay: run=%b, required 0", running);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    vecs++;
    if (T0 !== 1'b1 || running !== 1'b1 || PC !== 16'h0000 || instr_cnt !== 16'h0001) begin
      miss++;
      $display("FAIL halt_resume: T0=%b run=%b PC=%h cnt=%h, required 1/1/0000/0001",
               T0, running, PC, instr_cnt);
    end
  endtask

  // Entered in B0 with PC=0000, cnt=0001; jump and halt together in B3.
  task automatic test_jump_halt();
    cyc(); cyc(); cyc();
    halt = 1'b1; PC_jump_en = 1'b1; PC_jump_data = 16'h0ABC;
    cyc();
    halt = 1'b0; PC_jump_en = 1'b0;
    vecs++;
    if (running !== 1'b0 || PC !== 16'h0ABC || PC_jump_ack !== 1'b1 || instr_cnt !== 16'h0002) begin
      miss++;
      $display("FAIL jump_halt: run=%b PC=%h ack=%b cnt=%h, required 0/0ABC/1/0002",
               running, PC, PC_jump_ack, instr_cnt);
    end
    cyc();
    vecs++;
    if (PC_jump_ack !== 1'b0 || running !== 1'b0 || PC !== 16'h0ABC) begin
      miss++;
      $display("FAIL jump_halt_after: ack=%b run=%b PC=%h, required 0/0/0ABC", PC_jump_ack, running, PC);
    end
  endtask

  // Reset lands on the B2 edge together with a jump request.
  task automatic test_reset_mid();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    vecs++;
    if (T2 !== 1'b1 || PC !== 16'h0ABD) begin
      miss++;
      $display("FAIL rst_mid_pre: T2=%b PC=%h, required 1/0ABD", T2, PC);
    end
    rst = 1'b1; PC_jump_en = 1'b1; PC_jump_data = 16'h5555;
    cyc();
    rst = 1'b0; PC_jump_en = 1'b0;
    vecs++;
    if ({T0, T1, T2, T3} !== 4'b0000 || running !== 1'b0 || PC !== 16'h0000 ||
        instr_cnt !== 16'h0000 || PC_jump_ack !== 1'b0) begin
      miss++;
      $display("FAIL rst_mid: T=%b run=%b PC=%h cnt=%h ack=%b, required 0000/0/0000/0000/0",
               {T0, T1, T2, T3}, running, PC, instr_cnt, PC_jump_ack);
    end
    cyc();
    vecs++;
    if (running !== 1'b0 || PC_jump_ack !== 1'b0 || PC !== 16'h0000) begin
      miss++;
      $display("FAIL rst_mid_after: run=%b ack=%b PC=%h, required 0/0/0000", running, PC_jump_ack, PC);
    end
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    rst = 1'b1; start = 1'b0; halt = 1'b0; PC_jump_en = 1'b0; PC_jump_data = 16'h0000;
    @(negedge clk);
    test_reset();
    test_two_instr();
    test_jump();
    test_jump_ignored();
    test_wrap();
    test_halt();
    test_jump_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at 100000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
